pdm_sequence_mux: RTL and testbench
===================================

Name: pdm_sequence_mux

Overview:
- Parametrised, registered successor to the PDM buffer multiplexer.
- Steps through a flat multi-channel PDM sample buffer, one word per step pulse, starting at a configurable address over a configurable length.
- Runs in continuous (wrap) or single-shot mode.
- Sits between the PDM buffer registers and the per-channel PDM modulators; emits one registered, channel-masked word per step together with a valid pulse.

Parameters:
- N_CHANNELS, 4, number of PDM channels packed per buffer word.
- CHANNEL_WIDTH, 16, bits per channel value.
- DEPTH, 128, number of buffer words; must be a power of two.
- ADDR_WIDTH, 7, log2(DEPTH).

Ports:
- aclk  in  1  system clock.
- aresetn  in  1  asynchronous active-low reset.
- pdm_data_in  in  DEPTH*N_CHANNELS*CHANNEL_WIDTH  flat buffer; word k = bits [k*W +: W], W = N_CHANNELS*CHANNEL_WIDTH; channel c of a word = bits [c*CHANNEL_WIDTH +: CHANNEL_WIDTH].
- enable  in  1  level; high runs the sequencer, low returns it to IDLE.
- mode_single  in  1  1 = single-shot, 0 = continuous wrap.
- start_addr  in  ADDR_WIDTH  first word address.
- seq_length  in  ADDR_WIDTH+1  number of words per pass.
- step  in  1  single-cycle advance strobe.
- channel_mask  in  N_CHANNELS  1 = channel passed, 0 = channel forced to zero.
- pdm_data_out  out  N_CHANNELS*CHANNEL_WIDTH  registered output word.
- pdm_valid  out  1  one-cycle pulse when pdm_data_out updates.
- current_addr  out  ADDR_WIDTH  address of the next word to be emitted.
- running  out  1  high in RUN.
- wrap_pulse  out  1  one-cycle pulse when a continuous pass completes.
- done  out  1  level; high in DONE.

Behaviour:
- Reset (aresetn low, asynchronous): state = IDLE; all outputs 0; internal index = 0; latched config = 0.
- States: IDLE, RUN, DONE. Registered transitions only.
- IDLE, enable=1: go to RUN next cycle. On that edge, latch start_addr, seq_length and mode_single. Set idx=0 and current_addr=start_addr. Steps in the entry cycle are ignored.
- Effective length L: latched seq_length; a value of 0 or greater than DEPTH is treated as DEPTH.
- RUN, step=1, enable=1, on the same edge:
  - pdm_data_out <= word[current_addr] with masked channels zeroed; channel_mask is sampled live.
  - pdm_valid = 1 for one cycle.
  - If idx < L-1: idx+1; current_addr = (start_addr+idx+1) mod DEPTH (natural ADDR_WIDTH wrap).
  - If idx = L-1 and continuous: idx=0; current_addr=start_addr; wrap_pulse=1 for one cycle.
  - If idx = L-1 and single-shot: go to DONE; done=1.
- Latency: one cycle from step to pdm_data_out/pdm_valid. Back-to-back steps emit back-to-back words.
- DONE: step is ignored; pdm_data_out holds; done stays high until enable=0.
- enable=0 in RUN or DONE: go to IDLE next cycle. running and done clear, pdm_data_out holds its last value, and no valid pulse is issued. enable=0 wins over a simultaneous step: no word is emitted.
- running = (state==RUN); done = (state==DONE).
- Input changes during RUN: start_addr, seq_length and mode_single have no effect until the next IDLE→RUN entry.
- pdm_data_in is sampled only at step edges; no internal copy is kept.
- Reset mid-operation: immediate return to the reset values; any pending step is lost.

Test Plan:
- Reset: assert aresetn=0 mid-RUN → all outputs 0 asynchronously; after release, state IDLE with running=0.
- Continuous wrap: DEPTH=128, word k = {4{k[15:0]}}, start_addr=126, seq_length=4, mask=4'b1111, enable, 6 steps →
  - outputs 126, 127, 0, 1, 126, 127;
  - wrap_pulse on the 4th valid;
  - current_addr after the 6th step = 0.
- Single-shot: start_addr=10, seq_length=3, mode_single=1, 5 steps →
  - exactly 3 valids (10, 11, 12);
  - done=1 after the 3rd; steps 4–5 produce no valid;
  - enable=0 → done clears next cycle.
- Channel mask: mask=4'b0101, word 5 = 0xDDDD_CCCC_BBBB_AAAA → pdm_data_out = 0x0000_CCCC_0000_AAAA; changing mask between steps takes effect on the next step.
- Length clamp: seq_length=0 and seq_length=200, start_addr=0, continuous → wrap_pulse after exactly 128 steps in both cases.
- Simultaneous events and latching:
  - enable dropped in the same cycle as step → no valid; IDLE next cycle; pdm_data_out unchanged.
  - seq_length changed during RUN → pass length stays at the latched value.

Source files
------------

// File: rtl/pdm_sequence_mux.sv
// Steps through a flat multi-channel PDM buffer one word per step pulse and emits a registered,
// channel-masked word with a valid pulse; runs continuously (wrapping) or as a single pass.
module pdm_sequence_mux #(
  parameter int unsigned N_CHANNELS    = 4,
  parameter int unsigned CHANNEL_WIDTH = 16,
  parameter int unsigned DEPTH         = 128,
  parameter int unsigned ADDR_WIDTH    = 7
) (
  input  logic                                        aclk,
  input  logic                                        aresetn,
  input  logic [DEPTH*N_CHANNELS*CHANNEL_WIDTH-1:0]   pdm_data_in,
  input  logic                                        enable,
  input  logic                                        mode_single,
  input  logic [ADDR_WIDTH-1:0]                       start_addr,
  input  logic [ADDR_WIDTH:0]                         seq_length,
  input  logic                                        step,
  input  logic [N_CHANNELS-1:0]                       channel_mask,
  output logic [N_CHANNELS*CHANNEL_WIDTH-1:0]         pdm_data_out,
  output logic                                        pdm_valid,
  output logic [ADDR_WIDTH-1:0]                       current_addr,
  output logic                                        running,
  output logic                                        wrap_pulse,
  output logic                                        done
);

  localparam int unsigned W = N_CHANNELS * CHANNEL_WIDTH;
  localparam logic [ADDR_WIDTH:0] DepthL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] OneL   = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] start_q, start_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic                  single_q, single_d;
  logic [W-1:0]          data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  wrap_q, wrap_d;

  logic [ADDR_WIDTH:0]   len_eff;
  logic                  last_word;
  logic [W-1:0]          word_sel;
  logic [W-1:0]          word_masked;

  // Zero and oversize lengths both mean a full pass over the buffer.
  assign len_eff   = (len_q == '0 || len_q > DepthL) ? DepthL : len_q;
  assign last_word = ({1'b0, idx_q} == (len_eff - OneL));
  assign word_sel  = pdm_data_in[int'(addr_q) * W +: W];

  always_comb begin
    word_masked = word_sel;
    for (int c = 0; c < N_CHANNELS; c++) begin
      if (!channel_mask[c]) begin
        word_masked[c*CHANNEL_WIDTH +: CHANNEL_WIDTH] = '0;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    addr_d   = addr_q;
    idx_d    = idx_q;
    len_d    = len_q;
    single_d = single_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    wrap_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d  = StRun;
          start_d  = start_addr;
          len_d    = seq_length;
          single_d = mode_single;
          idx_d    = '0;
          addr_d   = start_addr;
        end
      end
      StRun: begin
        // Dropping enable takes priority over a coincident step.
        if (!enable) begin
          state_d = StIdle;
        end else if (step) begin
          data_d  = word_masked;
          valid_d = 1'b1;
          if (!last_word) begin
            idx_d  = idx_q + 1'b1;
            addr_d = addr_q + 1'b1;
          end else if (single_q) begin
            state_d = StDone;
          end else begin
            idx_d  = '0;
            addr_d = start_q;
            wrap_d = 1'b1;
          end
        end
      end
      StDone: begin
        if (!enable) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= StIdle;
      start_q  <= '0;
      addr_q   <= '0;
      idx_q    <= '0;
      len_q    <= '0;
      single_q <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      addr_q   <= addr_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      single_q <= single_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
    end
  end

  assign pdm_data_out = data_q;
  assign pdm_valid    = valid_q;
  assign current_addr = addr_q;
  assign running      = (state_q == StRun);
  assign wrap_pulse   = wrap_q;
  assign done         = (state_q == StDone);

endmodule

// File: tb/tb_pdm_sequence_mux.sv
// Directed bench for pdm_sequence_mux: a pass-counting model checked every cycle, plus
// hand-computed expectations for each scenario.
module tb_pdm_sequence_mux;

  localparam int NC = 4;
  localparam int CW = 16;
  localparam int D  = 128;
  localparam int AW = 7;
  localparam int W  = NC * CW;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b1;
  logic [D*W-1:0]  pdm_data_in;
  logic            enable = 1'b0;
  logic            mode_single = 1'b0;
  logic [AW-1:0]   start_addr = '0;
  logic [AW:0]     seq_length = '0;
  logic            step = 1'b0;
  logic [NC-1:0]   channel_mask = '1;
  logic [W-1:0]    pdm_data_out;
  logic            pdm_valid;
  logic [AW-1:0]   current_addr;
  logic            running;
  logic            wrap_pulse;
  logic            done;

  logic [W-1:0]    mem [D];
  int              vectors = 0;
  int              miscompares = 0;
  bit              checking = 1'b0;
  logic [W-1:0]    got_words[$];
  bit              got_wraps[$];

  always #5 aclk = ~aclk;

  for (genvar k = 0; k < D; k++) begin : g_buf
    assign pdm_data_in[k*W +: W] = mem[k];
  end

  pdm_sequence_mux dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .pdm_data_in  (pdm_data_in),
    .enable       (enable),
    .mode_single  (mode_single),
    .start_addr   (start_addr),
    .seq_length   (seq_length),
    .step         (step),
    .channel_mask (channel_mask),
    .pdm_data_out (pdm_data_out),
    .pdm_valid    (pdm_valid),
    .current_addr (current_addr),
    .running      (running),
    .wrap_pulse   (wrap_pulse),
    .done         (done)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] masked_word(input int a, input logic [NC-1:0] m);
    logic [W-1:0] r;
    r = mem[a % D];
    for (int c = 0; c < NC; c++) if (!m[c]) r[c*CW +: CW] = '0;
    return r;
  endfunction

  // Model: a run is a count of words emitted in the current pass.
  int           m_state = 0;  // 0 idle, 1 run, 2 done
  int           m_start = 0;
  int           m_len = 0;
  int           m_cnt = 0;
  int           m_addr = 0;
  bit           m_single = 1'b0;
  logic [W-1:0] e_data = '0;
  bit           e_valid = 1'b0;
  bit           e_wrap = 1'b0;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_state = 0; m_start = 0; m_len = 0; m_cnt = 0; m_addr = 0; m_single = 0;
      e_data = '0; e_valid = 0; e_wrap = 0;
    end else begin
      e_valid = 0;
      e_wrap  = 0;
      case (m_state)
        0: if (enable) begin
          m_state  = 1;
          m_start  = int'(start_addr);
          m_len    = (seq_length == 0 || int'(seq_length) > D) ? D : int'(seq_length);
          m_single = mode_single;
          m_cnt    = 0;
          m_addr   = m_start;
        end
        1: if (!enable) begin
          m_state = 0;
        end else if (step) begin
          e_data  = masked_word(m_start + m_cnt, channel_mask);
          e_valid = 1;
          m_cnt++;
          if (m_cnt < m_len) begin
            m_addr = (m_start + m_cnt) % D;
          end else if (m_single) begin
            m_state = 2;
          end else begin
            m_cnt  = 0;
            m_addr = m_start;
            e_wrap = 1;
          end
        end
        default: if (!enable) m_state = 0;
      endcase
    end
  end

  always @(negedge aclk) begin
    if (checking) begin
      check("data", pdm_data_out, e_data);
      check("valid", W'(pdm_valid), W'(e_valid));
      check("addr", W'(current_addr), W'(m_addr));
      check("running", W'(running), W'(m_state == 1));
      check("wrap", W'(wrap_pulse), W'(e_wrap));
      check("done", W'(done), W'(m_state == 2));
      if (pdm_valid) begin
        got_words.push_back(pdm_data_out);
        got_wraps.push_back(wrap_pulse);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge aclk);
      #1;
    end
  endtask

  task automatic start_run(input int a, input int len, input bit single);
    start_addr  = AW'(a);
    seq_length  = (AW + 1)'(len);
    mode_single = single;
    enable      = 1'b1;
    tick();
    got_words.delete();
    got_wraps.delete();
  endtask

  task automatic steps(input int n);
    step = 1'b1;
    tick(n);
    step = 1'b0;
  endtask

  task automatic stop_run();
    enable = 1'b0;
    tick(2);
  endtask

  initial begin
    int exp_wrap[6];
    int wrap_idx;
    int wrap_cnt;
    int lens[2];
    exp_wrap = '{126, 127, 0, 1, 126, 127};
    lens     = '{0, 200};
    for (int k = 0; k < D; k++) mem[k] = {NC{16'(k)}};
    mem[5] = 64'hDDDD_CCCC_BBBB_AAAA;

    #1 aresetn = 1'b0;
    checking = 1'b1;
    #20;
    tick();
    aresetn = 1'b1;
    tick();
    check("reset_running", W'(running), '0);
    check("reset_data", pdm_data_out, '0);

    // Continuous wrap across the top of the buffer.
    start_run(126, 4, 0);
    steps(6);
    check("wrap_count", W'(got_words.size()), W'(6));
    for (int i = 0; i < 6 && i < got_words.size(); i++) begin
      check("wrap_word", got_words[i], {NC{16'(exp_wrap[i])}});
      check("wrap_flag", W'(got_wraps[i]), W'(i == 3));
    end
    check("wrap_next_addr", W'(current_addr), '0);

    // Asynchronous reset mid-run with a step pending.
    step = 1'b1;
    #2 aresetn = 1'b0;
    enable = 1'b0;
    #1;
    check("arst_data", pdm_data_out, '0);
    check("arst_flags", W'({pdm_valid, running, wrap_pulse, done}), '0);
    check("arst_addr", W'(current_addr), '0);
    step = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();
    check("arst_idle", W'(running), '0);

    // Single-shot pass of three words.
    start_run(10, 3, 1);
    steps(5);
    check("single_count", W'(got_words.size()), W'(3));
    for (int i = 0; i < 3 && i < got_words.size(); i++)
      check("single_word", got_words[i], {NC{16'(10 + i)}});
    check("single_done", W'(done), W'(1));
    enable = 1'b0;
    tick();
    check("single_done_clear", W'(done), '0);
    tick();

    // Channel mask sampled live per step.
    channel_mask = 4'b0101;
    start_run(5, 2, 0);
    steps(1);
    channel_mask = 4'b1111;
    steps(1);
    check("mask_word0", got_words.size() > 0 ? got_words[0] : '1, 64'h0000_CCCC_0000_AAAA);
    check("mask_word1", got_words.size() > 1 ? got_words[1] : '1, 64'h0006_0006_0006_0006);
    stop_run();

    // Length clamp: 0 and 200 both give a 128-word pass.
    for (int t = 0; t < 2; t++) begin
      start_run(0, lens[t], 0);
      steps(130);
      wrap_idx = -1;
      wrap_cnt = 0;
      foreach (got_wraps[i]) begin
        if (got_wraps[i]) begin
          wrap_cnt++;
          if (wrap_idx < 0) wrap_idx = i;
        end
      end
      check("clamp_wrap_idx", W'(wrap_idx), W'(127));
      check("clamp_wrap_cnt", W'(wrap_cnt), W'(1));
      stop_run();
    end

    // enable drop wins over a coincident step.
    start_run(20, 8, 0);
    steps(2);
    got_words.delete();
    step   = 1'b1;
    enable = 1'b0;
    tick();
    step = 1'b0;
    check("drop_no_valid", W'(got_words.size()), '0);
    check("drop_hold", pdm_data_out, {NC{16'd21}});
    check("drop_idle", W'(running), '0);
    tick();

    // seq_length change during RUN is ignored.
    start_run(0, 4, 0);
    seq_length = 8'd2;
    steps(4);
    check("latch_count", W'(got_words.size()), W'(4));
    for (int i = 0; i < 4 && i < got_wraps.size(); i++)
      check("latch_wrap", W'(got_wraps[i]), W'(i == 3));
    stop_run();

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
